// File: rtl/main_mem_line_fetcher.sv
// Bridges the cache controller's line-wide main-memory port to a 32-bit word bus:
// 16-beat line reads, single-word write-through, and a per-beat timeout.
module main_mem_line_fetcher #(
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned TO_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              main_mem_addr,
  input  logic [31:0]              main_mem_data_out,
  input  logic                     main_mem_read_req,
  input  logic                     main_mem_write_req,
  output logic [LINE_WORDS*32-1:0] main_mem_data_in,
  output logic                     main_mem_ready,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [31:0]              bus_addr,
  output logic [31:0]              bus_wdata,
  input  logic                     bus_ack,
  input  logic [31:0]              bus_rdata,
  output logic                     err_timeout,
  output logic                     err_protocol
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = BEAT_W + 2;
  localparam int unsigned LINE_W = LINE_WORDS * 32;

  typedef enum logic [1:0] {S_IDLE, S_RD_BEAT, S_WR_BEAT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [31:0]         base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [31:0]         bus_addr_q, bus_addr_d;
  logic                ready_q, ready_d;
  logic                err_to_q, err_to_d;
  logic                err_pr_q, err_pr_d;
  logic                timed_out_c;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^main_mem_addr[1:0];

  // Timeout fires on the TIMEOUT-th consecutive un-acked request cycle.
  assign timed_out_c = !bus_ack && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    to_cnt_d   = to_cnt_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    bus_req_d  = bus_req_q;
    bus_we_d   = bus_we_q;
    bus_addr_d = bus_addr_q;
    err_to_d   = err_to_q;
    err_pr_d   = err_pr_q;
    ready_d    = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (main_mem_write_req) begin
          wdata_d    = main_mem_data_out;
          bus_addr_d = {main_mem_addr[31:2], 2'b00};
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b1;
          to_cnt_d   = '0;
          state_d    = S_WR_BEAT;
          if (main_mem_read_req) err_pr_d = 1'b1;
        end else if (main_mem_read_req) begin
          base_d     = {main_mem_addr[31:OFF_W], OFF_W'(0)};
          bus_addr_d = {main_mem_addr[31:OFF_W], OFF_W'(0)};
          beat_d     = '0;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          to_cnt_d   = '0;
          state_d    = S_RD_BEAT;
        end
      end

      S_RD_BEAT: begin
        if (bus_ack) begin
          for (int k = 0; k < int'(LINE_WORDS); k++) begin
            if (beat_q == BEAT_W'(k)) line_d[k*32 +: 32] = bus_rdata;
          end
          to_cnt_d = '0;
          if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
            bus_req_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            beat_d     = beat_q + BEAT_W'(1);
            bus_addr_d = {base_q[31:OFF_W], beat_q + BEAT_W'(1), 2'b00};
          end
        end else if (timed_out_c) begin
          bus_req_d = 1'b0;
          err_to_d  = 1'b1;
          to_cnt_d  = '0;
          state_d   = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_WR_BEAT: begin
        if (bus_ack || timed_out_c) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          to_cnt_d  = '0;
          state_d   = S_DONE;
          if (!bus_ack) err_to_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      to_cnt_q   <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      ready_q    <= 1'b0;
      err_to_q   <= 1'b0;
      err_pr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      to_cnt_q   <= to_cnt_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      ready_q    <= ready_d;
      err_to_q   <= err_to_d;
      err_pr_q   <= err_pr_d;
    end
  end

  assign main_mem_data_in = line_q;
  assign main_mem_ready   = ready_q;
  assign bus_req          = bus_req_q;
  assign bus_we           = bus_we_q;
  assign bus_addr         = bus_addr_q;
  assign bus_wdata        = wdata_q;
  assign err_timeout      = err_to_q;
  assign err_protocol     = err_pr_q;

endmodule

// File: tb/tb_main_mem_line_fetcher.sv
// Bench for main_mem_line_fetcher: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_main_mem_line_fetcher;

  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  main_mem_addr, main_mem_data_out;
  logic         main_mem_read_req, main_mem_write_req;
  logic [511:0] main_mem_data_in;
  logic         main_mem_ready;
  logic         bus_req, bus_we;
  logic [31:0]  bus_addr, bus_wdata;
  logic         bus_ack;
  logic [31:0]  bus_rdata;
  logic         err_timeout, err_protocol;

  always #5 clk = ~clk;

  main_mem_line_fetcher #(.LINE_WORDS(16), .TIMEOUT(TO), .TO_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .main_mem_addr(main_mem_addr), .main_mem_data_out(main_mem_data_out),
    .main_mem_read_req(main_mem_read_req), .main_mem_write_req(main_mem_write_req),
    .main_mem_data_in(main_mem_data_in), .main_mem_ready(main_mem_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .err_timeout(err_timeout), .err_protocol(err_protocol)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: one outstanding transaction, ready two edges after completion.
  bit          m_busy = 0, m_we = 0, m_err_to = 0, m_err_pr = 0;
  logic [31:0] m_base = 0, m_waddr = 0, m_wdata = 0;
  int          m_beat = 0, m_wait = 0, m_stage = 0;
  logic [31:0] m_line [16];

  function automatic logic [511:0] m_flat();
    logic [511:0] f;
    for (int k = 0; k < 16; k++) f[k*32 +: 32] = m_line[k];
    return f;
  endfunction

  always @(posedge clk) begin : model
    int old_stage;
    bit was_busy;
    if (rst) begin
      m_busy = 0; m_we = 0; m_err_to = 0; m_err_pr = 0; m_stage = 0;
      m_beat = 0; m_wait = 0;
      for (int k = 0; k < 16; k++) m_line[k] = 32'h0;
    end else begin
      old_stage = m_stage;
      was_busy  = m_busy;
      m_stage   = (old_stage == 1) ? 2 : 0;
      if (was_busy) begin
        if (bus_ack) begin
          m_wait = 0;
          if (!m_we) begin
            m_line[m_beat] = bus_rdata;
            m_beat++;
            if (m_beat == 16) begin m_busy = 0; m_stage = 1; end
          end else begin
            m_busy = 0; m_stage = 1;
          end
        end else begin
          m_wait++;
          if (m_wait == int'(TO)) begin m_busy = 0; m_err_to = 1; m_stage = 1; end
        end
      end else if (old_stage != 1) begin
        if (main_mem_write_req) begin
          m_busy = 1; m_we = 1; m_wait = 0;
          m_waddr = {main_mem_addr[31:2], 2'b00};
          m_wdata = main_mem_data_out;
          if (main_mem_read_req) m_err_pr = 1;
        end else if (main_mem_read_req) begin
          m_busy = 1; m_we = 0; m_wait = 0; m_beat = 0;
          m_base = {main_mem_addr[31:6], 6'b0};
        end
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("bus_req", 512'(bus_req), 512'(m_busy));
      chk("ready", 512'(main_mem_ready), 512'(m_stage == 2));
      chk("err_timeout", 512'(err_timeout), 512'(m_err_to));
      chk("err_protocol", 512'(err_protocol), 512'(m_err_pr));
      chk("line", main_mem_data_in, m_flat());
      if (m_busy) begin
        chk("bus_we", 512'(bus_we), 512'(m_we));
        if (m_we) begin
          chk("wr_addr", 512'(bus_addr), 512'(m_waddr));
          chk("wr_data", 512'(bus_wdata), 512'(m_wdata));
        end else begin
          chk("rd_addr", 512'(bus_addr), 512'(m_base + 32'(4 * m_beat)));
        end
      end
    end
  end

  // Bus slave: 0 = ack always high, 1 = never ack, 2 = per-beat wait in [wlo,whi].
  int          ack_mode = 0, wlo = 0, whi = 0, w_left = 0;
  logic [31:0] rkey = 32'h0;
  always @(negedge clk) begin
    if (ack_mode == 0) bus_ack = 1'b1;
    else if (ack_mode == 1) bus_ack = 1'b0;
    else if (bus_req) begin
      if (w_left == 0) begin
        bus_ack = 1'b1;
        w_left  = $urandom_range(whi, wlo);
      end else begin
        bus_ack = 1'b0;
        w_left--;
      end
    end else bus_ack = 1'b0;
    bus_rdata = bus_addr ^ rkey;
  end

  int beats = 0, req_hi = 0;
  always @(posedge clk) if (!rst && bus_req && bus_ack) beats++;
  always @(negedge clk) if (bus_req) req_hi++;

  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int inject_n, output int lat);
    int n = 0;
    bit seen = 0;
    lat = -1;
    main_mem_read_req = rd; main_mem_write_req = wr;
    main_mem_addr = a; main_mem_data_out = d;
    while (n < 300) begin
      @(negedge clk);
      n++;
      main_mem_read_req  = (inject_n != 0 && n == inject_n);
      main_mem_write_req = 1'b0;
      if (bus_req && !seen) begin
        seen = 1; cap_addr = bus_addr; cap_we = bus_we; cap_wdata = bus_wdata;
      end
      if (main_mem_ready) begin lat = n - 1; break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [511:0] exp_line;
  int lat, n, rdy_cnt;

  initial begin
    rst = 1'b1; main_mem_read_req = 0; main_mem_write_req = 0;
    main_mem_addr = 0; main_mem_data_out = 0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 512'(bus_req), 512'(0));
    chk("rst_ready", 512'(main_mem_ready), 512'(0));
    chk("rst_bus_addr", 512'(bus_addr), 512'(0));
    chk("rst_bus_we", 512'(bus_we), 512'(0));
    chk("rst_line", main_mem_data_in, 512'(0));
    chk("rst_errs", 512'({err_timeout, err_protocol}), 512'(0));
    rst = 1'b0; chk_en = 1;
    @(negedge clk);

    // 1: aligned line read, ack tied high, rdata = address
    ack_mode = 0; rkey = 32'h0;
    for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = 32'h1200 + 32'(4 * k);
    beats = 0;
    do_req(1, 0, 32'h0000_1234, 32'h0, 0, lat);
    chk("t1_latency", 512'(lat), 512'(17));
    chk("t1_first_addr", 512'(cap_addr), 512'(32'h1200));
    chk("t1_word0", 512'(main_mem_data_in[31:0]), 512'(32'h1200));
    chk("t1_word15", 512'(main_mem_data_in[511:480]), 512'(32'h123C));
    chk("t1_line", main_mem_data_in, exp_line);
    chk("t1_beats", 512'(beats), 512'(16));

    // 2: write-through with 3 wait cycles
    ack_mode = 2; wlo = 3; whi = 3; w_left = 3; beats = 0;
    do_req(0, 1, 32'h0000_0ABF, 32'hDEAD_BEEF, 0, lat);
    chk("t2_latency", 512'(lat), 512'(5));
    chk("t2_addr", 512'(cap_addr), 512'(32'hABC));
    chk("t2_we", 512'(cap_we), 512'(1));
    chk("t2_wdata", 512'(cap_wdata), 512'(32'hDEAD_BEEF));
    chk("t2_line_kept", main_mem_data_in, exp_line);
    chk("t2_beats", 512'(beats), 512'(1));

    // 3: read with random 0-5 cycle stalls
    ack_mode = 2; wlo = 0; whi = 5; w_left = 2; rkey = 32'hA5A5_0000; beats = 0;
    do_req(1, 0, 32'h0000_8F3C, 32'h0, 0, lat);
    chk("t3_done", 512'(lat > 16), 512'(1));
    chk("t3_word3", 512'(main_mem_data_in[127:96]), 512'(32'hA5A5_8F0C));
    chk("t3_beats", 512'(beats), 512'(16));

    // 4: bus never acks -> timeout, then a normal read
    ack_mode = 1; req_hi = 0;
    do_req(1, 0, 32'h0000_4000, 32'h0, 0, lat);
    chk("t4_req_cycles", 512'(req_hi), 512'(TO));
    chk("t4_latency", 512'(lat), 512'(TO + 1));
    chk("t4_err_timeout", 512'(err_timeout), 512'(1));
    chk("t4_word3_kept", 512'(main_mem_data_in[127:96]), 512'(32'hA5A5_8F0C));
    ack_mode = 0; rkey = 32'h0;
    do_req(1, 0, 32'h0000_0040, 32'h0, 0, lat);
    chk("t4_reread_lat", 512'(lat), 512'(17));
    chk("t4_reread_w0", 512'(main_mem_data_in[31:0]), 512'(32'h40));

    // 5: simultaneous read+write, then a read while busy
    ack_mode = 2; wlo = 3; whi = 3; w_left = 3; beats = 0;
    do_req(1, 1, 32'h0000_0100, 32'h1122_3344, 2, lat);
    chk("t5_latency", 512'(lat), 512'(5));
    chk("t5_we", 512'(cap_we), 512'(1));
    chk("t5_addr", 512'(cap_addr), 512'(32'h100));
    chk("t5_err_protocol", 512'(err_protocol), 512'(1));
    repeat (4) @(negedge clk);
    chk("t5_beats", 512'(beats), 512'(1));

    // 6: reset in the middle of a read
    ack_mode = 0;
    main_mem_read_req = 1; main_mem_addr = 32'h0000_3000;
    n = 0;
    do begin
      @(negedge clk);
      main_mem_read_req = 0;
      n++;
    end while (m_beat != 7 && n < 50);
    chk("t6_reach_beat7", 512'(m_beat), 512'(7));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_bus_req", 512'(bus_req), 512'(0));
    chk("t6_ready", 512'(main_mem_ready), 512'(0));
    chk("t6_addr", 512'(bus_addr), 512'(0));
    chk("t6_line", main_mem_data_in, 512'(0));
    chk("t6_errs", 512'({err_timeout, err_protocol}), 512'(0));
    rdy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (main_mem_ready) rdy_cnt++;
    end
    chk("t6_no_ready", 512'(rdy_cnt), 512'(0));
    do_req(1, 0, 32'h0000_5004, 32'h0, 0, lat);
    chk("t6_read_lat", 512'(lat), 512'(17));
    chk("t6_word1", 512'(main_mem_data_in[63:32]), 512'(32'h5004));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
